dcache_wb: RTL and testbench
============================

// Module: dcache_wb
// PURPOSE
//  Parametrised direct-mapped, write-back, write-allocate data cache for the proc datapath.
//  Successor to the fixed 4x128-bit cache:
//   - lines start invalid at reset (no preloaded contents);
//   - misses are handled by an evict/fill FSM over a line-wide memory handshake;
//   - dirty victims are written back before the refill.
//  Sits between the MEM stage (single req/rsp port) and the memory model / next level.
// PARAMETERS
//  ADDR_BITS  32   address width (proc.ARCH_BITS)
//  DATA_BITS  32   CPU word width; power of 2, >= 8
//  LINES      4    number of lines; power of 2, >= 2
//  LINE_SIZE  128  line width in bits; multiple of DATA_BITS
//  Derived: WORDS=LINE_SIZE/DATA_BITS, OFF_B=clog2(DATA_BITS/8), OFF_W=clog2(WORDS),
//   IDX=clog2(LINES), TAG=ADDR_BITS-IDX-OFF_W-OFF_B.
//  Address split (MSB..LSB): tag | index | word offset | byte offset.
// PORTS
//  clk         in   1          clock; all state changes on posedge
//  rst         in   1          asynchronous, active-high reset
//  req_valid   in   1          CPU request present
//  req_we      in   1          1=write word, 0=read word
//  req_addr    in   ADDR_BITS  byte address; byte offset ignored
//  req_wdata   in   DATA_BITS  write data
//  req_ready   out  1          cache can accept a request this cycle
//  rsp_valid   out  1          one-cycle pulse: request completed
//  rsp_rdata   out  DATA_BITS  read data, valid with rsp_valid (reads only)
//  mem_req     out  1          memory transaction request, held until mem_ack
//  mem_we      out  1          1=line write-back, 0=line fill
//  mem_addr    out  ADDR_BITS  line-aligned address (low OFF_W+OFF_B bits zero)
//  mem_wline   out  LINE_SIZE  victim line data for write-back
//  mem_ack     in   1          one-cycle pulse: transaction done; fill data valid this cycle
//  mem_rline   in   LINE_SIZE  fill data; word w occupies bits [(w+1)*DATA_BITS-1 -: DATA_BITS]
// BEHAVIOUR
//  Reset (async): all valid and dirty bits = 0; FSM = IDLE; req_ready=1, rsp_valid=0,
//   rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wline=0. Data/tag arrays are not reset.
//  Accept: request is captured in a request register when req_valid && req_ready.
//  FSM states: IDLE, LOOKUP, WB, FILL, DONE. req_ready=1 only in IDLE.
//   IDLE -> LOOKUP on accept.
//   LOOKUP, hit (valid && tag match):
//    - read returns the word; write merges the word and sets dirty;
//    - rsp_valid=1 next cycle -> IDLE. Hit latency = 1 cycle after accept.
//   LOOKUP, miss: -> WB if the victim is valid && dirty, else -> FILL.
//   WB: mem_req=1, mem_we=1, mem_addr={victim tag, idx, 0}, mem_wline=victim line.
//    On mem_ack: dirty=0, -> FILL.
//   FILL: mem_req=1, mem_we=0, mem_addr={req tag, idx, 0}.
//    On mem_ack: install mem_rline and the tag, valid=1, -> DONE.
//    For a write, the req word is merged into the installed line, dirty=1.
//   DONE: rsp_valid=1; rsp_rdata = word from the installed line (reads) -> IDLE.
//  Memory outputs are registered and stable while mem_req=1. mem_req drops in the cycle after
//   mem_ack. mem_ack outside WB/FILL is ignored.
//  No back-to-back accept: at most one outstanding request.
//   Throughput: 1 request per 2 cycles on hits.
//  Request fields are sampled only at accept; changes afterwards have no effect.
//  Reset mid-operation (any state, including WB/FILL while waiting for mem_ack):
//   immediate return to reset values; the pending request is dropped with no rsp_valid.
//   A late mem_ack after reset is ignored.
//  Word select uses the word offset only; no unaligned or byte writes.
// STRUCTURE
//  Shared package/include cache_pkg: clog2 function, FSM state encodings, address-field
//   helper macros (tag/idx/woff extraction).
//  Sub-module cache_data_array: LINES x LINE_SIZE storage with a combinational read port and a
//   write port supporting full-line install plus single-word merge.
//  Tags, valid and dirty bits and the FSM live in dcache_wb.
// TESTING (defaults; 0x100 -> idx0/tag4, 0x140 -> idx0/tag5)
//  1 Reset, read 0x100 -> mem_req=1, mem_we=0, mem_addr=0x100. Ack with
//    mem_rline=128'h44444444_33333333_22222222_11111111 -> rsp_valid pulse, rsp_rdata=0x11111111.
//  2 Read 0x10C -> no mem_req; rsp_valid 1 cycle after accept; rsp_rdata=0x44444444.
//  3 Write 0x108=0xDEADBEEF (hit), then read 0x108 -> rsp_rdata=0xDEADBEEF, no mem traffic.
//  4 Read 0x140 -> WB first: mem_we=1, mem_addr=0x100,
//    mem_wline=128'h44444444_DEADBEEF_22222222_11111111; then FILL at 0x140; rsp_valid after ack.
//  5 Write miss 0x204=0x12345678 on a clean line -> FILL 0x200 only (no WB); line dirty.
//    A later conflict (0x300) triggers WB at 0x200 with word1=0x12345678.
//  6 Assert rst while in FILL waiting -> mem_req=0, req_ready=1 at once, no rsp_valid.
//    A stray mem_ack is ignored; read 0x100 misses again.

Source files
------------

// File: rtl/dcache_wb_pkg.sv
// Shared definitions for the write-back data cache: FSM state encodings and
// a constant-evaluable ceil(log2) used to derive address field widths.
package dcache_wb_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOOKUP = 3'd1;
   localparam logic [2:0] ST_WB     = 3'd2;
   localparam logic [2:0] ST_FILL   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// CPU request/response port plus line-wide memory handshake of the data cache.
// slave = cache view, master = CPU + memory environment view.
interface dcache_wb_if #(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 32,
   parameter int LINE_SIZE = 128
);
   logic                 req_valid;
   logic                 req_we;
   logic [ADDR_BITS-1:0] req_addr;
   logic [DATA_BITS-1:0] req_wdata;
   logic                 req_ready;
   logic                 rsp_valid;
   logic [DATA_BITS-1:0] rsp_rdata;
   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [LINE_SIZE-1:0] mem_wline;
   logic                 mem_ack;
   logic [LINE_SIZE-1:0] mem_rline;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rline,
      output req_ready, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wline
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rline,
      input  req_ready, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wline
   );
endinterface

// File: rtl/dcache_wb_data_array.sv
// Line storage: combinational read port, write port that installs a full line
// and/or merges a single word (both at once for a write-allocate fill).
module dcache_wb_data_array #(
   parameter int LINES     = 4,
   parameter int LINE_SIZE = 128,
   parameter int DATA_BITS = 32,
   parameter int IDX_BITS  = 2,
   parameter int WOFF_BITS = 2
) (
   input  logic                 clk,
   input  logic [IDX_BITS-1:0]  rd_idx,
   output logic [LINE_SIZE-1:0] rd_line,
   input  logic                 wr_en,
   input  logic                 wr_full,
   input  logic                 wr_word_en,
   input  logic [IDX_BITS-1:0]  wr_idx,
   input  logic [WOFF_BITS-1:0] wr_woff,
   input  logic [LINE_SIZE-1:0] wr_line,
   input  logic [DATA_BITS-1:0] wr_word
);
   logic [LINE_SIZE-1:0] lines_r [LINES];
   logic [LINE_SIZE-1:0] base_line_s;
   logic [LINE_SIZE-1:0] next_line_s;

   assign rd_line = lines_r[rd_idx];

   // Merged line: new fill data or current contents, with the word overlay on top.
   always_comb begin
      base_line_s = wr_full ? wr_line : lines_r[wr_idx];
      next_line_s = base_line_s;
      if (wr_word_en) begin
         next_line_s[wr_woff*DATA_BITS +: DATA_BITS] = wr_word;
      end else begin
         next_line_s = base_line_s;
      end
   end

   // Contents are intentionally not reset; valid bits in the tag store guard them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         lines_r[wr_idx] <= next_line_s;
      end
   end
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with an evict/fill FSM
// driving a line-wide memory handshake. One outstanding request at a time.
module dcache_wb
   import dcache_wb_pkg::*;
#(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 32,
   parameter int LINES     = 4,
   parameter int LINE_SIZE = 128
) (
   input  logic       clk,
   input  logic       rst,
   dcache_wb_if.slave bus
);
   localparam int WORDS = LINE_SIZE / DATA_BITS;
   localparam int OFF_B = clog2(DATA_BITS / 8);
   localparam int OFF_W = clog2(WORDS);
   localparam int IDX   = clog2(LINES);
   localparam int TAG   = ADDR_BITS - IDX - OFF_W - OFF_B;
   localparam int LOW   = OFF_W + OFF_B;

   logic [2:0]           state_r;
   logic                 req_we_r;
   logic [TAG-1:0]       req_tag_r;
   logic [IDX-1:0]       req_idx_r;
   logic [OFF_W-1:0]     req_woff_r;
   logic [DATA_BITS-1:0] req_wdata_r;
   logic [TAG-1:0]       tags_r [LINES];
   logic [LINES-1:0]     valid_r;
   logic [LINES-1:0]     dirty_r;

   logic                 accept_s;
   logic                 hit_s;
   logic                 fill_done_s;
   logic                 wr_en_s;
   logic [LINE_SIZE-1:0] rd_line_s;
   logic [DATA_BITS-1:0] rd_word_s;
   logic [DATA_BITS-1:0] fill_word_s;

   assign accept_s    = bus.req_valid && bus.req_ready;
   assign hit_s       = valid_r[req_idx_r] && (tags_r[req_idx_r] == req_tag_r);
   assign fill_done_s = (state_r == ST_FILL) && bus.mem_req && bus.mem_ack;
   assign wr_en_s     = fill_done_s || ((state_r == ST_LOOKUP) && hit_s && req_we_r);
   assign rd_word_s   = rd_line_s[req_woff_r*DATA_BITS +: DATA_BITS];
   assign fill_word_s = bus.mem_rline[req_woff_r*DATA_BITS +: DATA_BITS];

   dcache_wb_data_array #(
      .LINES     (LINES),
      .LINE_SIZE (LINE_SIZE),
      .DATA_BITS (DATA_BITS),
      .IDX_BITS  (IDX),
      .WOFF_BITS (OFF_W)
   ) u_data (
      .clk        (clk),
      .rd_idx     (req_idx_r),
      .rd_line    (rd_line_s),
      .wr_en      (wr_en_s),
      .wr_full    (fill_done_s),
      .wr_word_en (req_we_r),
      .wr_idx     (req_idx_r),
      .wr_woff    (req_woff_r),
      .wr_line    (bus.mem_rline),
      .wr_word    (req_wdata_r)
   );

   // Tags only matter once the matching valid bit is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (fill_done_s) begin
         tags_r[req_idx_r] <= req_tag_r;
      end
   end

   // Control FSM; every CPU- and memory-facing output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         valid_r       <= '0;
         dirty_r       <= '0;
         req_we_r      <= 1'b0;
         req_tag_r     <= '0;
         req_idx_r     <= '0;
         req_woff_r    <= '0;
         req_wdata_r   <= '0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wline <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_r       <= ST_LOOKUP;
                  bus.req_ready <= 1'b0;
                  req_we_r      <= bus.req_we;
                  req_tag_r     <= bus.req_addr[ADDR_BITS-1 -: TAG];
                  req_idx_r     <= bus.req_addr[LOW +: IDX];
                  req_woff_r    <= bus.req_addr[OFF_B +: OFF_W];
                  req_wdata_r   <= bus.req_wdata;
               end
            end
            ST_LOOKUP: begin
               if (hit_s) begin
                  state_r       <= ST_IDLE;
                  bus.req_ready <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= req_we_r ? '0 : rd_word_s;
                  if (req_we_r) begin
                     dirty_r[req_idx_r] <= 1'b1;
                  end
               end else if (valid_r[req_idx_r] && dirty_r[req_idx_r]) begin
                  state_r       <= ST_WB;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= {tags_r[req_idx_r], req_idx_r, {LOW{1'b0}}};
                  bus.mem_wline <= rd_line_s;
               end else begin
                  state_r      <= ST_FILL;
                  bus.mem_req  <= 1'b1;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= {req_tag_r, req_idx_r, {LOW{1'b0}}};
               end
            end
            ST_WB: begin
               if (bus.mem_ack) begin
                  state_r            <= ST_FILL;
                  bus.mem_req        <= 1'b0;
                  dirty_r[req_idx_r] <= 1'b0;
               end
            end
            ST_FILL: begin
               // After a write-back, mem_req idles for one cycle before the fill is issued.
               if (!bus.mem_req) begin
                  bus.mem_req  <= 1'b1;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= {req_tag_r, req_idx_r, {LOW{1'b0}}};
               end else if (bus.mem_ack) begin
                  state_r            <= ST_DONE;
                  bus.mem_req        <= 1'b0;
                  valid_r[req_idx_r] <= 1'b1;
                  dirty_r[req_idx_r] <= req_we_r;
                  bus.rsp_valid      <= 1'b1;
                  bus.rsp_rdata      <= req_we_r ? '0 : fill_word_s;
               end
            end
            ST_DONE: begin
               state_r       <= ST_IDLE;
               bus.req_ready <= 1'b1;
            end
            default: begin
               state_r       <= ST_IDLE;
               bus.req_ready <= 1'b1;
               bus.mem_req   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: a flat CPU-visible memory image plus a
// per-index residency model predict hits, write-backs, fills and read data.
module tb_dcache_wb;
   logic clk = 1'b0;
   logic rst;

   dcache_wb_if bus ();

   dcache_wb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit [127:0] backing [bit [31:0]];
   bit [31:0]  gold    [bit [31:0]];
   bit         mvalid  [4];
   bit         mdirty  [4];
   bit [25:0]  mtag    [4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit [31:0] init_word(input bit [31:0] waddr);
      return (waddr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic bit [127:0] mem_line(input bit [31:0] la);
      bit [127:0] l;
      if (backing.exists(la)) return backing[la];
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word(la + w * 4);
      return l;
   endfunction

   function automatic bit [31:0] cpu_word(input bit [31:0] waddr);
      bit [127:0] l;
      if (gold.exists(waddr)) return gold[waddr];
      l = mem_line(waddr & ~32'hF);
      return l[waddr[3:2]*32 +: 32];
   endfunction

   function automatic bit [127:0] cpu_line(input bit [31:0] la);
      bit [127:0] l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = cpu_word(la + w * 4);
      return l;
   endfunction

   task automatic do_req(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                         output bit [31:0] rdata, output bit was_hit, output bit saw_wb,
                         output bit [31:0] wb_addr, output bit [127:0] wb_line);
      bit [1:0]   idx;
      bit [25:0]  tag;
      bit [31:0]  la, waddr, victim_la, exp_rd, t_addr;
      bit [127:0] t_line;
      bit         exp_hit, wb_pend, fill_pend, done, in_txn, any_mem, t_we;
      int         ack_wait;
      idx       = addr[5:4];
      tag       = addr[31:6];
      la        = addr & ~32'hF;
      waddr     = addr & ~32'h3;
      exp_hit   = mvalid[idx] && (mtag[idx] == tag);
      wb_pend   = !exp_hit && mvalid[idx] && mdirty[idx];
      fill_pend = !exp_hit;
      victim_la = {mtag[idx], idx, 4'h0};
      exp_rd    = cpu_word(waddr);
      rdata = 32'h0; was_hit = 1'b0; saw_wb = 1'b0; wb_addr = 32'h0; wb_line = 128'h0;
      done = 1'b0; in_txn = 1'b0; any_mem = 1'b0; ack_wait = 0;
      t_we = 1'b0; t_addr = 32'h0; t_line = 128'h0;
      chk("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
      for (int c = 1; c <= 80 && !done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.req_valid = 1'b0;
            bus.req_we    = 1'($urandom_range(0, 1));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
         end
         if (bus.mem_ack) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rline = {$urandom, $urandom, $urandom, $urandom};
            chk("mem_req_drop", bus.mem_req, 1'b0);
         end else if (bus.mem_req) begin
            any_mem = 1'b1;
            if (!in_txn) begin
               in_txn = 1'b1; t_we = bus.mem_we; t_addr = bus.mem_addr; t_line = bus.mem_wline;
               ack_wait = $urandom_range(0, 3);
               if (wb_pend) begin
                  chk("wb_we", t_we, 1'b1);
                  chk("wb_addr", t_addr, victim_la);
                  chk("wb_line", t_line, cpu_line(victim_la));
               end else if (fill_pend) begin
                  chk("fill_we", t_we, 1'b0);
                  chk("fill_addr", t_addr, la);
               end else begin
                  chk("unexpected_mem_req", bus.mem_req, 1'b0);
               end
            end else begin
               chk("mem_we_stable", bus.mem_we, t_we);
               chk("mem_addr_stable", bus.mem_addr, t_addr);
               chk("mem_wline_stable", bus.mem_wline, t_line);
            end
            if (ack_wait == 0) begin
               bus.mem_ack = 1'b1;
               in_txn = 1'b0;
               if (t_we) begin
                  backing[t_addr] = t_line; wb_pend = 1'b0;
                  saw_wb = 1'b1; wb_addr = t_addr; wb_line = t_line;
               end else begin
                  bus.mem_rline = mem_line(t_addr); fill_pend = 1'b0;
               end
            end else begin
               ack_wait--;
            end
         end
         if (bus.rsp_valid) begin
            done = 1'b1; rdata = bus.rsp_rdata; was_hit = !any_mem;
            chk("pending_txn", {wb_pend, fill_pend}, 2'b00);
            if (exp_hit) chk("hit_latency", c, 2);
            if (!we) chk("rsp_rdata", rdata, exp_rd);
            if (we) gold[waddr] = wdata;
            mvalid[idx] = 1'b1; mtag[idx] = tag;
            if (we) mdirty[idx] = 1'b1;
            else if (!exp_hit) mdirty[idx] = 1'b0;
         end else begin
            chk("busy_not_ready", bus.req_ready, 1'b0);
         end
      end
      chk("rsp_timeout", done, 1'b1);
      @(negedge clk);
      chk("rsp_pulse", bus.rsp_valid, 1'b0);
      chk("ready_after", bus.req_ready, 1'b1);
   endtask

   initial begin
      bit [31:0]  rd, wa;
      bit [127:0] wl;
      bit         hit, wb, seen;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      bus.mem_ack = 1'b0; bus.mem_rline = 128'h0;
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_mem_we", bus.mem_we, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wline", bus.mem_wline, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      backing[32'h100] = 128'h44444444_33333333_22222222_11111111;

      do_req(1'b0, 32'h100, 32'h0, rd, hit, wb, wa, wl);
      chk("t1_rdata", rd, 32'h11111111);
      chk("t1_miss", hit, 1'b0);
      do_req(1'b0, 32'h10C, 32'h0, rd, hit, wb, wa, wl);
      chk("t2_rdata", rd, 32'h44444444);
      chk("t2_hit", hit, 1'b1);
      do_req(1'b1, 32'h108, 32'hDEADBEEF, rd, hit, wb, wa, wl);
      chk("t3_write_hit", hit, 1'b1);
      do_req(1'b0, 32'h108, 32'h0, rd, hit, wb, wa, wl);
      chk("t3_rdata", rd, 32'hDEADBEEF);
      do_req(1'b0, 32'h140, 32'h0, rd, hit, wb, wa, wl);
      chk("t4_wb_seen", wb, 1'b1);
      chk("t4_wb_addr", wa, 32'h100);
      chk("t4_wb_line", wl, 128'h44444444_DEADBEEF_22222222_11111111);
      do_req(1'b1, 32'h204, 32'h12345678, rd, hit, wb, wa, wl);
      chk("t5_no_wb", wb, 1'b0);
      chk("t5_miss", hit, 1'b0);
      do_req(1'b0, 32'h300, 32'h0, rd, hit, wb, wa, wl);
      chk("t5_wb_addr", wa, 32'h200);
      chk("t5_wb_word1", wl[63:32], 32'h12345678);

      // Reset while the fill for 0x100 is outstanding.
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h100;
      @(negedge clk);
      bus.req_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (bus.mem_req) seen = 1'b1;
      end
      chk("t6_fill_started", seen, 1'b1);
      chk("t6_fill_addr", bus.mem_addr, 32'h100);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_mem_req", bus.mem_req, 1'b0);
      chk("t6_req_ready", bus.req_ready, 1'b1);
      chk("t6_rsp_valid", bus.rsp_valid, 1'b0);
      chk("t6_mem_addr", bus.mem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ack = 1'b1; bus.mem_rline = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      bus.mem_ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t6_no_rsp", bus.rsp_valid, 1'b0);
         chk("t6_no_mem_req", bus.mem_req, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         mvalid[i] = 1'b0; mdirty[i] = 1'b0;
      end
      gold.delete();
      do_req(1'b0, 32'h100, 32'h0, rd, hit, wb, wa, wl);
      chk("t6_remiss", hit, 1'b0);
      chk("t6_rdata", rd, 32'h11111111);

      for (int n = 0; n < 250; n++) begin
         wa = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 4)
              | 32'($urandom_range(0, 15));
         do_req(1'($urandom_range(0, 1)), wa, $urandom, rd, hit, wb, wa, wl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
